// File: rtl/datapath_core.sv
// datapath_core: single-bus CPU datapath.
//   One combinational bus joins the general register file, PC/MAR/MDR, HI/LO,
//   the ALU staging registers Y and Z (ZLO/ZHI) and an external immediate.
//   Single-cycle ALU ops write Z on the edge that samples i_alu_go.
//   MUL and DIV run iteratively on operand magnitudes, with a busy/done handshake.
//
// Ports
//   i_clock, i_clear      clock and synchronous active-high clear
//   i_src_sel             bus source: 0..NREGS-1 Rn, then PC, MDR, MAR, HI, LO, ZLO, ZHI, imm
//   i_imm                 immediate value driven onto the bus
//   i_reg_in_en/_idx      load Rn from the bus
//   i_pc_in, i_pc_inc     PC load from the bus (wins) or PC+4
//   i_mar_in, i_mdr_in    MAR/MDR load from the bus
//   i_mdr_read            MDR load from i_mem_data_in (wins over i_mdr_in)
//   i_hi_in, i_lo_in      HI/LO load from the bus
//   i_y_in                Y load from the bus
//   i_alu_op, i_alu_go    ALU operation and start (A=Y, B=bus)
//   o_bus_out             current bus value
//   o_mar_out, o_mdr_out, o_pc_out   register contents
//   o_busy, o_done, o_div0           MUL/DIV in progress, completion pulse, sticky divide-by-zero
module datapath_core #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int R0_ZERO = 1
) (
    input  logic                         i_clock,
    input  logic                         i_clear,
    input  logic [$clog2(NREGS+8)-1:0]   i_src_sel,
    input  logic [WIDTH-1:0]             i_imm,
    input  logic                         i_reg_in_en,
    input  logic [$clog2(NREGS)-1:0]     i_reg_in_idx,
    input  logic                         i_pc_in,
    input  logic                         i_pc_inc,
    input  logic                         i_mar_in,
    input  logic                         i_mdr_in,
    input  logic                         i_mdr_read,
    input  logic                         i_hi_in,
    input  logic                         i_lo_in,
    input  logic                         i_y_in,
    input  logic [WIDTH-1:0]             i_mem_data_in,
    input  logic [3:0]                   i_alu_op,
    input  logic                         i_alu_go,
    output logic [WIDTH-1:0]             o_bus_out,
    output logic [WIDTH-1:0]             o_mar_out,
    output logic [WIDTH-1:0]             o_mdr_out,
    output logic [WIDTH-1:0]             o_pc_out,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_div0
);
    localparam int SELW = $clog2(NREGS + 8);
    localparam int IDXW = $clog2(NREGS);
    localparam int SHW  = $clog2(WIDTH);

    localparam logic [SELW-1:0] SEL_PC  = SELW'(NREGS);
    localparam logic [SELW-1:0] SEL_MDR = SELW'(NREGS + 1);
    localparam logic [SELW-1:0] SEL_MAR = SELW'(NREGS + 2);
    localparam logic [SELW-1:0] SEL_HI  = SELW'(NREGS + 3);
    localparam logic [SELW-1:0] SEL_LO  = SELW'(NREGS + 4);
    localparam logic [SELW-1:0] SEL_ZLO = SELW'(NREGS + 5);
    localparam logic [SELW-1:0] SEL_ZHI = SELW'(NREGS + 6);
    localparam logic [SELW-1:0] SEL_IMM = SELW'(NREGS + 7);

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHR = 4'd4,  OP_SRA = 4'd5,  OP_SHL = 4'd6,  OP_ROR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8,  OP_NEG = 4'd9,  OP_NOT = 4'd10, OP_MUL = 4'd11;
    localparam logic [3:0] OP_DIV = 4'd12, OP_INC = 4'd13;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FIN = 2'd2;

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [WIDTH-1:0] r_pc, r_mar, r_mdr, r_hi, r_lo, r_y, r_zlo, r_zhi;

    logic [1:0]       r_state;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_acc_hi, r_acc_lo, r_mag_b, r_dvd;
    logic             r_is_div, r_neg_main, r_neg_rem, r_b_zero, r_done, r_div0;

    logic [WIDTH-1:0]   w_bus, w_abs_a, w_abs_b;
    logic               w_is_md;
    logic [WIDTH:0]     w_msum, w_rsh;
    logic [WIDTH-1:0]   w_trial, w_quot, w_rem;
    logic               w_q_ok;
    logic [2*WIDTH-1:0] w_mag_prod, w_prod;

    function automatic logic [WIDTH-1:0] f_alu(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [3:0]       op);
        logic [SHW-1:0]          sh;
        logic [2*WIDTH-1:0]      dbl;
        logic signed [WIDTH-1:0] sa;
        logic [WIDTH-1:0]        res;
        sh  = b[SHW-1:0];
        sa  = a;
        res = '0;
        case (op)
            OP_ADD: res = a + b;
            OP_SUB: res = a - b;
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_SHR: res = a >> sh;
            OP_SRA: res = sa >>> sh;
            OP_SHL: res = a << sh;
            OP_ROR: begin
                // Rotations shift a doubled copy so that a zero amount needs no special case.
                dbl = {a, a} >> sh;
                res = dbl[WIDTH-1:0];
            end
            OP_ROL: begin
                dbl = {a, a} << sh;
                res = dbl[2*WIDTH-1:WIDTH];
            end
            OP_NEG: res = '0 - b;
            OP_NOT: res = ~b;
            OP_INC: res = b + WIDTH'(1);
            default: res = '0;
        endcase
        return res;
    endfunction

    // Bus source mux; unused select codes drive zero.
    always_comb begin
        w_bus = '0;
        if (i_src_sel < SEL_PC) begin
            if (R0_ZERO != 0 && i_src_sel[IDXW-1:0] == '0) begin
                w_bus = '0;
            end else begin
                w_bus = r_regs[i_src_sel[IDXW-1:0]];
            end
        end else begin
            case (i_src_sel)
                SEL_PC:  w_bus = r_pc;
                SEL_MDR: w_bus = r_mdr;
                SEL_MAR: w_bus = r_mar;
                SEL_HI:  w_bus = r_hi;
                SEL_LO:  w_bus = r_lo;
                SEL_ZLO: w_bus = r_zlo;
                SEL_ZHI: w_bus = r_zhi;
                SEL_IMM: w_bus = i_imm;
                default: w_bus = '0;
            endcase
        end
    end

    assign w_is_md = (i_alu_op == OP_MUL) || (i_alu_op == OP_DIV);
    assign w_abs_a = r_y[WIDTH-1] ? ('0 - r_y) : r_y;
    assign w_abs_b = w_bus[WIDTH-1] ? ('0 - w_bus) : w_bus;

    // Multiply step: add the multiplicand when the low multiplier bit is set, then shift {hi,lo} right.
    assign w_msum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag_b} : '0);

    // Restoring divide step: shift the next dividend bit into the partial remainder and try a subtract.
    assign w_rsh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_q_ok  = (w_rsh >= {1'b0, r_mag_b});
    assign w_trial = w_rsh[WIDTH-1:0] - r_mag_b;

    // Sign fix-up on the magnitude results.
    assign w_mag_prod = {r_acc_hi, r_acc_lo};
    assign w_prod     = r_neg_main ? ('0 - w_mag_prod) : w_mag_prod;
    assign w_quot     = r_neg_main ? ('0 - r_acc_lo) : r_acc_lo;
    assign w_rem      = r_neg_rem ? ('0 - r_acc_hi) : r_acc_hi;

    // Bus-loaded registers.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pc  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_y   <= '0;
        end else begin
            if (i_reg_in_en && !(R0_ZERO != 0 && i_reg_in_idx == '0)) begin
                r_regs[i_reg_in_idx] <= w_bus;
            end
            if (i_pc_in) begin
                r_pc <= w_bus;
            end else if (i_pc_inc) begin
                r_pc <= r_pc + WIDTH'(4);
            end
            if (i_mdr_read) begin
                r_mdr <= i_mem_data_in;
            end else if (i_mdr_in) begin
                r_mdr <= w_bus;
            end
            if (i_mar_in) r_mar <= w_bus;
            if (i_hi_in)  r_hi  <= w_bus;
            if (i_lo_in)  r_lo  <= w_bus;
            if (i_y_in)   r_y   <= w_bus;
        end
    end

    // ALU result register Z and the MUL/DIV sequencer.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_mag_b    <= '0;
            r_dvd      <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_b_zero   <= 1'b0;
            r_done     <= 1'b0;
            r_div0     <= 1'b0;
            r_zlo      <= '0;
            r_zhi      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_alu_go) begin
                        r_div0 <= 1'b0;
                        if (w_is_md) begin
                            r_is_div   <= (i_alu_op == OP_DIV);
                            r_neg_main <= r_y[WIDTH-1] ^ w_bus[WIDTH-1];
                            r_neg_rem  <= r_y[WIDTH-1];
                            r_dvd      <= r_y;
                            r_b_zero   <= (w_bus == '0);
                            r_acc_hi   <= '0;
                            // MUL shifts the multiplier (bus) through acc_lo; DIV shifts the dividend (Y).
                            if (i_alu_op == OP_DIV) begin
                                r_acc_lo <= w_abs_a;
                                r_mag_b  <= w_abs_b;
                            end else begin
                                r_acc_lo <= w_abs_b;
                                r_mag_b  <= w_abs_a;
                            end
                            r_cnt   <= SHW'(WIDTH - 1);
                            r_state <= ST_RUN;
                        end else begin
                            r_zlo <= f_alu(r_y, w_bus, i_alu_op);
                            r_zhi <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_is_div) begin
                        r_acc_hi <= w_q_ok ? w_trial : w_rsh[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_q_ok};
                    end else begin
                        r_acc_hi <= w_msum[WIDTH:1];
                        r_acc_lo <= {w_msum[0], r_acc_lo[WIDTH-1:1]};
                    end
                    if (r_cnt == '0) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_cnt <= r_cnt - SHW'(1);
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                    if (r_is_div) begin
                        if (r_b_zero) begin
                            r_zlo  <= '1;
                            r_zhi  <= r_dvd;
                            r_div0 <= 1'b1;
                        end else begin
                            r_zlo <= w_quot;
                            r_zhi <= w_rem;
                        end
                    end else begin
                        r_zhi <= w_prod[2*WIDTH-1:WIDTH];
                        r_zlo <= w_prod[WIDTH-1:0];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_bus_out = w_bus;
    assign o_mar_out = r_mar;
    assign o_mdr_out = r_mdr;
    assign o_pc_out  = r_pc;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = r_done;
    assign o_div0    = r_div0;
endmodule

// File: tb/tb_datapath_core.sv
module tb_datapath_core;
    localparam int W  = 32;
    localparam int NR = 16;
    localparam logic [4:0] SEL_PC  = 5'd16, SEL_MDR = 5'd17, SEL_MAR = 5'd18, SEL_HI  = 5'd19;
    localparam logic [4:0] SEL_LO  = 5'd20, SEL_ZLO = 5'd21, SEL_ZHI = 5'd22, SEL_IMM = 5'd23;

    logic          clock;
    logic          clear;
    logic [4:0]    src_sel;
    logic [W-1:0]  imm;
    logic          reg_in_en;
    logic [3:0]    reg_in_idx;
    logic          pc_in, pc_inc, mar_in, mdr_in, mdr_read, hi_in, lo_in, y_in;
    logic [W-1:0]  mem_data_in;
    logic [3:0]    alu_op;
    logic          alu_go;
    logic [W-1:0]  bus_out, mar_out, mdr_out, pc_out;
    logic          busy, done, div0;

    int n_total = 0;
    int n_bad   = 0;

    datapath_core #(.WIDTH(W), .NREGS(NR), .R0_ZERO(1)) dut (
        .i_clock(clock), .i_clear(clear), .i_src_sel(src_sel), .i_imm(imm),
        .i_reg_in_en(reg_in_en), .i_reg_in_idx(reg_in_idx),
        .i_pc_in(pc_in), .i_pc_inc(pc_inc), .i_mar_in(mar_in), .i_mdr_in(mdr_in),
        .i_mdr_read(mdr_read), .i_hi_in(hi_in), .i_lo_in(lo_in), .i_y_in(y_in),
        .i_mem_data_in(mem_data_in), .i_alu_op(alu_op), .i_alu_go(alu_go),
        .o_bus_out(bus_out), .o_mar_out(mar_out), .o_mdr_out(mdr_out), .o_pc_out(pc_out),
        .o_busy(busy), .o_done(done), .o_div0(div0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] zlo;
        logic [31:0] zhi;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic read_bus(input logic [4:0] sel, output logic [31:0] val);
        src_sel = sel;
        #1;
        val = bus_out;
    endtask

    task automatic load_y(input logic [31:0] v);
        imm = v; src_sel = SEL_IMM; y_in = 1'b1;
        step();
        y_in = 1'b0;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] b);
        imm = b; src_sel = SEL_IMM; alu_op = op; alu_go = 1'b1;
        step();
        alu_go = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] zlo, output logic [31:0] zhi);
        load_y(a);
        alu(op, b);
        wait_idle("run_op");
        read_bus(SEL_ZLO, zlo);
        read_bus(SEL_ZHI, zhi);
    endtask

    // Reference model: results from plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] zlo, output logic [31:0] zhi, output logic dz);
        int unsigned s;
        longint      sa, sb, p;
        logic [63:0] pv;
        s   = b % 32;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        zlo = '0;
        zhi = '0;
        dz  = 1'b0;
        case (op)
            4'd0:  zlo = a + b;
            4'd1:  zlo = a - b;
            4'd2:  zlo = a & b;
            4'd3:  zlo = a | b;
            4'd4:  zlo = a >> s;
            4'd5:  begin p = sa >>> s; pv = p; zlo = pv[31:0]; end
            4'd6:  zlo = a << s;
            4'd7:  begin zlo = a; repeat (s) zlo = {zlo[0], zlo[31:1]}; end
            4'd8:  begin zlo = a; repeat (s) zlo = {zlo[30:0], zlo[31]}; end
            4'd9:  zlo = 32'd0 - b;
            4'd10: zlo = ~b;
            4'd13: zlo = b + 32'd1;
            4'd11: begin p = sa * sb; pv = p; zlo = pv[31:0]; zhi = pv[63:32]; end
            4'd12: begin
                if (b == 32'd0) begin
                    zlo = 32'hFFFFFFFF; zhi = a; dz = 1'b1;
                end else begin
                    p = sa / sb; pv = p; zlo = pv[31:0];
                    p = sa % sb; pv = p; zhi = pv[31:0];
                end
            end
            default: zlo = '0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input int unsigned kind);
        logic [31:0] v;
        case (kind)
            0: v = 32'h80000000;
            1: v = 32'd0;
            2: v = 32'($urandom_range(0, 20)) - 32'd10;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] v, zl, zh, el, eh;
        logic        ed;
        int          cnt, ndone;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        clear = 1'b1; src_sel = SEL_PC; imm = '0; reg_in_en = 1'b0; reg_in_idx = '0;
        pc_in = 1'b0; pc_inc = 1'b0; mar_in = 1'b0; mdr_in = 1'b0; mdr_read = 1'b0;
        hi_in = 1'b0; lo_in = 1'b0; y_in = 1'b0; mem_data_in = '0; alu_op = '0; alu_go = 1'b0;
        step(); step();
        clear = 1'b0;
        step();

        // Reset state
        check("rst_pc", pc_out, 0);
        check("rst_mar", mar_out, 0);
        check("rst_mdr", mdr_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div0", div0, 0);
        read_bus(SEL_PC, v);  check("rst_bus_pc", v, 0);
        read_bus(5'd5, v);    check("rst_bus_r5", v, 0);
        read_bus(SEL_ZLO, v); check("rst_bus_zlo", v, 0);

        // Register file write/readback
        for (int n = 0; n < NR; n++) begin
            imm = 32'hA5A50000 + 32'(n); src_sel = SEL_IMM;
            reg_in_en = 1'b1; reg_in_idx = 4'(n);
            step();
        end
        reg_in_en = 1'b0;
        for (int n = 0; n < NR; n++) begin
            read_bus(5'(n), v);
            check($sformatf("reg_r%0d", n), v, (n == 0) ? 64'd0 : 64'(32'hA5A50000 + 32'(n)));
        end
        read_bus(5'd31, v); check("bus_out_of_range", v, 0);

        // Table of directed ALU vectors
        vecs.push_back('{4'd0,  32'd7,          32'd5,          32'd12,         32'd0,          1'b0});
        vecs.push_back('{4'd1,  32'd7,          32'd5,          32'd2,          32'd0,          1'b0});
        vecs.push_back('{4'd5,  32'h80000000,   32'd4,          32'hF8000000,   32'd0,          1'b0});
        vecs.push_back('{4'd8,  32'h80000000,   32'd4,          32'h00000008,   32'd0,          1'b0});
        vecs.push_back('{4'd2,  32'h0000F0F0,   32'h0000FF00,   32'h0000F000,   32'd0,          1'b0});
        vecs.push_back('{4'd3,  32'h0000F0F0,   32'h0000FF00,   32'h0000FFF0,   32'd0,          1'b0});
        vecs.push_back('{4'd4,  32'h80000000,   32'd4,          32'h08000000,   32'd0,          1'b0});
        vecs.push_back('{4'd6,  32'd1,          32'd36,         32'h00000010,   32'd0,          1'b0});
        vecs.push_back('{4'd7,  32'd1,          32'd1,          32'h80000000,   32'd0,          1'b0});
        vecs.push_back('{4'd9,  32'd0,          32'd1,          32'hFFFFFFFF,   32'd0,          1'b0});
        vecs.push_back('{4'd10, 32'd0,          32'd0,          32'hFFFFFFFF,   32'd0,          1'b0});
        vecs.push_back('{4'd13, 32'd0,          32'hFFFFFFFF,   32'd0,          32'd0,          1'b0});
        vecs.push_back('{4'd14, 32'd5,          32'd5,          32'd0,          32'd0,          1'b0});
        vecs.push_back('{4'd11, 32'hFFFFFFFD,   32'd7,          32'hFFFFFFEB,   32'hFFFFFFFF,   1'b0});
        vecs.push_back('{4'd12, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0});
        vecs.push_back('{4'd12, 32'd9,          32'd0,          32'hFFFFFFFF,   32'd9,          1'b1});
        vecs.push_back('{4'd12, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0});
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, zl, zh);
            check($sformatf("vec%0d_zlo", i), zl, vecs[i].zlo);
            check($sformatf("vec%0d_zhi", i), zh, vecs[i].zhi);
            check($sformatf("vec%0d_div0", i), div0, vecs[i].dz);
        end
        // div0 from the last divide-by-zero is cleared by the next alu_go
        run_op(4'd12, 32'd9, 32'd0, zl, zh);
        check("div0_set", div0, 1);
        alu(4'd0, 32'd1);
        check("div0_cleared", div0, 0);

        // MUL latency, single done pulse, alu_go accepted in the done cycle
        load_y(32'hFFFFFFFD);
        alu(4'd11, 32'd7);
        cnt = 0; ndone = 0;
        while (busy && cnt < 100) begin
            if (done) ndone++;
            step();
            cnt++;
        end
        check("mul_busy_cycles", cnt, 33);
        check("mul_no_early_done", ndone, 0);
        check("mul_done_pulse", done, 1);
        read_bus(SEL_ZLO, v); check("mul_zlo", v, 32'hFFFFFFEB);
        read_bus(SEL_ZHI, v); check("mul_zhi", v, 32'hFFFFFFFF);
        alu(4'd0, 32'd10);
        check("done_one_cycle", done, 0);
        check("go_in_done_busy", busy, 0);
        read_bus(SEL_ZLO, v); check("go_in_done_zlo", v, 32'd7);

        // alu_go during busy ignored, Z holds, R3 load completes
        run_op(4'd0, 32'd1, 32'd1, zl, zh);
        load_y(32'd6);
        alu(4'd11, 32'd7);
        step(); step();
        read_bus(SEL_ZLO, v); check("z_hold_busy", v, 32'd2);
        imm = 32'h1234; src_sel = SEL_IMM; alu_op = 4'd0; alu_go = 1'b1;
        reg_in_en = 1'b1; reg_in_idx = 4'd3;
        step();
        alu_go = 1'b0; reg_in_en = 1'b0;
        wait_idle("mul_ignore");
        read_bus(SEL_ZLO, v); check("ignored_go_zlo", v, 32'd42);
        read_bus(SEL_ZHI, v); check("ignored_go_zhi", v, 32'd0);
        read_bus(5'd3, v);    check("r3_load_busy", v, 32'h1234);

        // clear mid-MUL aborts with no result
        load_y(32'd6);
        alu(4'd11, 32'd7);
        repeat (10) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        read_bus(SEL_ZLO, v); check("clr_zlo", v, 0);
        read_bus(SEL_ZHI, v); check("clr_zhi", v, 0);
        ndone = 0;
        repeat (40) begin
            step();
            if (done || busy) ndone++;
        end
        check("clr_no_done", ndone, 0);

        // PC priority and wrap
        imm = 32'h1234; src_sel = SEL_IMM; pc_in = 1'b1; pc_inc = 1'b1;
        step();
        pc_in = 1'b0;
        check("pc_in_over_inc", pc_out, 32'h1234);
        step();
        pc_inc = 1'b0;
        check("pc_inc", pc_out, 32'h1238);
        imm = 32'hFFFFFFFC; src_sel = SEL_IMM; pc_in = 1'b1;
        step();
        pc_in = 1'b0; pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        check("pc_wrap", pc_out, 0);

        // MDR priority, MAR, HI/LO
        imm = 32'h11111111; src_sel = SEL_IMM; mem_data_in = 32'hDEADBEEF;
        mdr_read = 1'b1; mdr_in = 1'b1;
        step();
        mdr_read = 1'b0;
        check("mdr_read_over_in", mdr_out, 32'hDEADBEEF);
        step();
        mdr_in = 1'b0;
        check("mdr_in", mdr_out, 32'h11111111);
        imm = 32'hCAFE0000; src_sel = SEL_IMM; mar_in = 1'b1; hi_in = 1'b1;
        step();
        mar_in = 1'b0; hi_in = 1'b0;
        imm = 32'h00000066; lo_in = 1'b1;
        step();
        lo_in = 1'b0;
        check("mar_out", mar_out, 32'hCAFE0000);
        read_bus(SEL_MAR, v); check("bus_mar", v, 32'hCAFE0000);
        read_bus(SEL_MDR, v); check("bus_mdr", v, 32'h11111111);
        read_bus(SEL_HI, v);  check("bus_hi", v, 32'hCAFE0000);
        read_bus(SEL_LO, v);  check("bus_lo", v, 32'h00000066);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            if (i % 4 == 0) rop = (i % 8 == 0) ? 4'd11 : 4'd12;
            ra = pick($urandom_range(0, 5));
            rb = pick($urandom_range(0, 5));
            model(rop, ra, rb, el, eh, ed);
            run_op(rop, ra, rb, zl, zh);
            check($sformatf("rand%0d_op%0d_zlo", i, rop), zl, el);
            check($sformatf("rand%0d_op%0d_zhi", i, rop), zh, eh);
            check($sformatf("rand%0d_op%0d_div0", i, rop), div0, ed);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
